// File: rtl/fwd_operand_mux4_pkg.sv
// fwd_operand_mux4_pkg: select encodings shared by the forwarding unit and the operand muxes
package fwd_operand_mux4_pkg;
  typedef enum logic [1:0] {
    FWD_REG       = 2'd0,
    FWD_EXMEM_ALU = 2'd1,
    FWD_MEMWB_ALU = 2'd2,
    FWD_MEMWB_LMD = 2'd3
  } fwd_sel_e;
endpackage

// File: rtl/fwd_operand_mux4.sv
// fwd_operand_mux4: ID-stage forwarding operand mux with zero flag and enable-gated registered copy
//   clk, reset(async, active-low), en(capture enable, low = stall hold)
//   in0 regfile, in1 EX/MEM ALU, in2 MEM/WB ALU, in3 MEM/WB load data, sel(2b)
//   out/out_zero combinational; out_q/sel_q registered together
module fwd_operand_mux4
  import fwd_operand_mux4_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       sel_q
);
  logic [WIDTH-1:0] out_d;
  logic [1:0]       sel_d;
  // Starting from X lets an unknown select show up as X in simulation; all real codes are covered.
  always_comb begin
    out = 'x;
    case (sel)
      FWD_REG:       out = in0;
      FWD_EXMEM_ALU: out = in1;
      FWD_MEMWB_ALU: out = in2;
      FWD_MEMWB_LMD: out = in3;
    endcase
  end
  assign out_zero = ~|out;
  assign out_d    = en ? out : out_q;
  assign sel_d    = en ? sel : sel_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= RESET_VAL;
      sel_q <= 2'b00;
    end else begin
      out_q <= out_d;
      sel_q <= sel_d;
    end
  end
endmodule

// File: tb/tb_fwd_operand_mux4.sv
// tb_fwd_operand_mux4: scoreboard-driven self-checking bench for fwd_operand_mux4
module tb_fwd_operand_mux4;
  typedef struct {
    logic [31:0] d;
    logic        z;
    logic [1:0]  s;
  } exp_t;
  exp_t        sb[$];
  exp_t        e;
  logic        clk = 1'b0;
  logic        clk_run = 1'b1;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [31:0] src[4];
  logic [1:0]  sel = 2'd0;
  logic [31:0] out, out_q;
  logic        out_zero;
  logic [1:0]  sel_q;
  int          vectors = 0;
  int          miscompares = 0;
  always #5 clk = clk_run ? ~clk : 1'b0;
  fwd_operand_mux4 #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
    .clk(clk), .reset(reset), .en(en),
    .in0(src[0]), .in1(src[1]), .in2(src[2]), .in3(src[3]),
    .sel(sel), .out(out), .out_zero(out_zero), .out_q(out_q), .sel_q(sel_q)
  );
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
  task automatic push_exp(input logic [31:0] d, input logic [1:0] s);
    exp_t x;
    x.d = d;
    x.z = (d == 32'h0);
    x.s = s;
    sb.push_back(x);
  endtask
  task automatic chk_comb(input string name);
    e = sb.pop_front();
    vectors++;
    if (out !== e.d || out_zero !== e.z) begin
      miscompares++;
      $display("FAIL %s: out=%h zero=%b, expected out=%h zero=%b", name, out, out_zero, e.d, e.z);
    end
  endtask
  task automatic chk_reg(input string name);
    e = sb.pop_front();
    vectors++;
    if (out_q !== e.d || sel_q !== e.s) begin
      miscompares++;
      $display("FAIL %s: out_q=%h sel_q=%0d, expected out_q=%h sel_q=%0d", name, out_q, sel_q, e.d, e.s);
    end
  endtask
  task automatic test_reset();
    src[0] = 32'h0; src[1] = 32'h0; src[2] = 32'h0; src[3] = 32'h0;
    reset = 1'b0;
    en = 1'b1;
    sel = 2'd3;
    src[3] = 32'h9999_0000;
    push_exp(32'h0, 2'd0);
    repeat (2) @(posedge clk);
    #1 chk_reg("reset_state");
    push_exp(32'h9999_0000, 2'd3);
    chk_comb("out_during_reset");
    @(negedge clk);
    reset = 1'b1;
    en = 1'b0;
  endtask
  task automatic test_sel_sweep();
    src[0] = 32'h11111111; src[1] = 32'h22222222; src[2] = 32'h33333333; src[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      push_exp(32'h11111111 * (i + 1), 2'(i));
      #1 chk_comb($sformatf("sel_sweep_%0d", i));
    end
  endtask
  task automatic test_isolation();
    sel = 2'd2;
    for (int i = 0; i < 6; i++) begin
      src[0] = $urandom; src[1] = $urandom; src[3] = $urandom;
      push_exp(32'h33333333, 2'd2);
      #1 chk_comb($sformatf("isolation_%0d", i));
    end
    src[2] = 32'hDEADBEEF;
    push_exp(32'hDEADBEEF, 2'd2);
    #1 chk_comb("isolation_selected_change");
  endtask
  task automatic test_zero();
    sel = 2'd1; src[1] = 32'h0;
    push_exp(32'h0, 2'd1);
    #1 chk_comb("zero_sel1");
    src[1] = 32'h00000001;
    push_exp(32'h1, 2'd1);
    #1 chk_comb("nonzero_sel1");
    sel = 2'd3; src[3] = 32'h0;
    push_exp(32'h0, 2'd3);
    #1 chk_comb("zero_sel3");
  endtask
  task automatic test_reg_enable();
    @(negedge clk);
    en = 1'b1; sel = 2'd3; src[3] = 32'hCAFEF00D;
    push_exp(32'hCAFEF00D, 2'd3);
    @(posedge clk);
    #1 chk_reg("capture_en1");
    @(negedge clk);
    en = 1'b0; sel = 2'd0; src[0] = 32'd5;
    push_exp(32'hCAFEF00D, 2'd3);
    push_exp(32'd5, 2'd0);
    repeat (2) @(posedge clk);
    #1 chk_reg("hold_en0");
    chk_comb("out_while_hold");
  endtask
  task automatic test_async_reset();
    clk_run = 1'b0;
    #12;
    en = 1'b1;
    reset = 1'b0;
    push_exp(32'h0, 2'd0);
    #1 chk_reg("async_reset_immediate");
    src[0] = 32'h0000_0077;
    push_exp(32'h77, 2'd0);
    #1 chk_comb("out_tracks_in_reset");
    push_exp(32'h0, 2'd0);
    #3 chk_reg("reset_holds_en1");
    reset = 1'b1;
    sel = 2'd1; src[1] = 32'h0000_ABCD;
    push_exp(32'hABCD, 2'd1);
    clk_run = 1'b1;
    @(posedge clk);
    #1 chk_reg("capture_after_release");
  endtask
  task automatic test_reset_priority();
    @(negedge clk);
    en = 1'b1; sel = 2'd2; src[2] = 32'h1234_5678;
    push_exp(32'h0, 2'd0);
    @(posedge clk);
    reset = 1'b0;
    #1 chk_reg("reset_priority");
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic test_back_to_back();
    logic [31:0] mq = 32'h0;
    logic [1:0]  ms = 2'd0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) src[k] = (i % 5 == 0) ? 32'h0 : $urandom;
      sel = 2'($urandom_range(0, 3));
      en = (i % 4 != 3);
      push_exp(src[sel], sel);
      #1 chk_comb($sformatf("b2b_comb_%0d", i));
      if (en) begin
        mq = src[sel];
        ms = sel;
      end
      push_exp(mq, ms);
      @(posedge clk);
      #1 chk_reg($sformatf("b2b_reg_%0d", i));
    end
  endtask
  initial begin
    test_reset();
    test_sel_sweep();
    test_isolation();
    test_zero();
    test_reg_enable();
    test_async_reset();
    test_reset_priority();
    test_back_to_back();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
